// File: rtl/midi_tx_pkg.sv
// Shared constants and MIDI byte classification for the midi_tx slice.
// Also provides the default F_CLK_HZ, F_BAUD and MIDI_PAYLOAD_BITS macros when no global definition exists.
`ifndef F_CLK_HZ
`define F_CLK_HZ 50_000_000
`endif
`ifndef F_BAUD
`define F_BAUD 31250
`endif
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

package midi_tx_pkg;
  localparam int unsigned PAYLOAD_BITS = `MIDI_PAYLOAD_BITS;

  typedef logic [PAYLOAD_BITS-1:0] midi_byte_t;

  typedef enum logic [1:0] {
    CLS_DATA     = 2'd0,
    CLS_CHANNEL  = 2'd1,
    CLS_SYSTEM   = 2'd2,
    CLS_REALTIME = 2'd3
  } byte_class_t;

  // Channel status 0x80-0xEF, system common/exclusive 0xF0-0xF7, real-time 0xF8-0xFF.
  function automatic byte_class_t classify(input midi_byte_t b);
    if (!b[7])                  return CLS_DATA;
    else if (b[7:4] != 4'hF)    return CLS_CHANNEL;
    else if (!b[3])             return CLS_SYSTEM;
    else                        return CLS_REALTIME;
  endfunction
endpackage

// File: rtl/midi_tx_if.sv
// Byte handshake between the controller core (master) and the MIDI transmitter (slave).
interface midi_tx_if;
  import midi_tx_pkg::*;

  midi_byte_t data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/midi_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; the extra pointer MSB separates full from empty.
module midi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr - r_rd;
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_wr == r_rd);
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: FIFO-buffered bytes serialised as 8N1 frames, LSB first, idle high.
// Optional MIDI_TX_RUNNING_STATUS_EN drops repeated channel-status bytes.
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_HZ     = `F_CLK_HZ,
  parameter int BAUD       = `F_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     nrst_i,
  midi_tx_if.slave s_if,
  output logic     txData_o,
  output logic     busy_o
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cyc;
  logic [2:0]  r_bit;
  midi_byte_t  r_shift;
  logic        r_tx;
  logic        r_busy;

  midi_byte_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_push;
  logic        w_pop;
  logic        w_discard;
  logic        w_launch;
  logic        w_bit_end;
  logic        w_frame_next;
  logic        w_fill_next;

  assign s_if.ready_o = !w_full;
  assign w_push       = s_if.valid_i && !w_full;
  assign w_bit_end    = (r_cyc == CW'(CPB - 1));
  assign w_pop        = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign w_launch     = w_pop && !w_discard;
  assign w_fill_next  = w_push || (w_count > (AW+1)'(w_pop));
  assign txData_o     = r_tx;
  assign busy_o       = r_busy;

  midi_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAYLOAD_BITS)) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .i_push  (w_push),
    .i_data  (s_if.data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef MIDI_TX_RUNNING_STATUS_EN
  midi_byte_t r_rs;
  logic       r_rs_valid;

  assign w_discard = w_pop && r_rs_valid && (w_head == r_rs);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_rs       <= '0;
      r_rs_valid <= 1'b0;
    end else if (w_launch) begin
      case (classify(w_head))
        CLS_CHANNEL: begin
          r_rs       <= w_head;
          r_rs_valid <= 1'b1;
        end
        CLS_SYSTEM: r_rs_valid <= 1'b0;
        default:    ;
      endcase
    end
  end
`else
  assign w_discard = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_frame_next = 1'b0;
    case (r_state)
      IDLE:        w_frame_next = w_launch;
      START, DATA: w_frame_next = 1'b1;
      STOP:        w_frame_next = w_bit_end ? w_launch : 1'b1;
      default:     w_frame_next = 1'b0;
    endcase
  end

  // txData_o is registered from the current state, so the line trails the state by one cycle.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_frame_next || w_fill_next;
      case (r_state)
        IDLE: begin
          r_tx  <= 1'b1;
          r_cyc <= '0;
          r_bit <= '0;
          if (w_launch) begin
            r_shift <= w_head;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= DATA;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_launch) begin
              r_shift <= w_head;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_cyc   <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: random byte streams against a frame-level reference model.
// Honours MIDI_TX_RUNNING_STATUS_EN in the model when the build defines it.
module tb_midi_tx;
  import midi_tx_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 31250;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * CPB;
  localparam int DEPTH  = 4;

  logic clk_i  = 1'b0;
  logic nrst_i = 1'b0;
  logic txData_o;
  logic busy_o;

  midi_tx_if bus ();

  midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .s_if     (bus),
    .txData_o (txData_o),
    .busy_o   (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int unsigned edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Line monitor: decodes frames and flags any bit not held constant for CPB cycles.
  logic [7:0]  mon_byte  [$];
  int unsigned mon_start [$];
  bit          mon_ok    [$];
  bit          mon_in_frame = 0;

  initial begin : monitor
    int          pos;
    logic [9:0]  bits;
    bit          ok;
    int unsigned st;
    pos = 0; bits = '0; ok = 1; st = 0;
    forever begin
      @(negedge clk_i);
      if (!nrst_i) begin
        mon_in_frame = 0;
      end else begin
        if (!mon_in_frame && txData_o === 1'b0) begin
          mon_in_frame = 1; pos = 0; ok = 1; st = edge_cnt;
        end
        if (mon_in_frame) begin
          if (pos % CPB == 0) bits[pos / CPB] = txData_o;
          else if (txData_o !== bits[pos / CPB]) ok = 0;
          pos++;
          if (pos == FRAME) begin
            mon_in_frame = 0;
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 0;
            mon_byte.push_back(bits[8:1]);
            mon_start.push_back(st);
            mon_ok.push_back(ok);
          end
        end
      end
    end
  end

  // Reference model: which accepted bytes should appear on the line, in order.
  logic [7:0] exp_q [$];
  bit         m_rs_valid = 0;
  logic [7:0] m_rs = '0;

  function void model_reset();
    m_rs_valid = 0;
    exp_q.delete();
  endfunction

  function void model_send(input logic [7:0] b);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (m_rs_valid && b == m_rs) return;
      m_rs_valid = 1;
      m_rs = b;
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_rs_valid = 0;
    end
`endif
    exp_q.push_back(b);
  endfunction

  function void mon_clear();
    mon_byte.delete();
    mon_start.delete();
    mon_ok.delete();
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    nrst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    model_reset();
    mon_clear();
    nrst_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic send_byte(input logic [7:0] b, output int unsigned acc);
    int budget;
    budget = 20 * FRAME;
    bus.data_i  = b;
    bus.valid_i = 1'b1;
    while (!bus.ready_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    check("accept_in_time", 32'(budget > 0), 32'd1);
    acc = edge_cnt + 1;
    model_send(b);
    @(negedge clk_i);
  endtask

  task automatic drain(output int unsigned fall_edge);
    int budget;
    budget = 40 * FRAME;
    while (busy_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    fall_edge = edge_cnt;
    check("drain_busy", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk_i);
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_nframes"}, mon_byte.size(), exp_q.size());
    for (int i = 0; i < mon_byte.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(mon_byte[i]), 32'(exp_q[i]));
      check($sformatf("%s_shape%0d", tag, i), 32'(mon_ok[i]), 32'd1);
    end
  endtask

  initial begin : stim
    int unsigned acc [5];
    int unsigned a0, fall;
    int          bad;
    int          budget;
    logic [7:0]  burst [5];
    logic [7:0]  rs_seq [10];

    burst  = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C};
    rs_seq = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h00, 8'hF8, 8'h90, 8'h40, 8'h7F};
    bus.data_i  = '0;
    bus.valid_i = 1'b0;

    // Reset values, then a long idle stretch.
    repeat (3) @(negedge clk_i);
    check("rst_tx", 32'(txData_o), 32'd1);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    nrst_i = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk_i);
      if (txData_o !== 1'b1 || bus.ready_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);

    // Single byte: start-bit latency, bit timing and busy fall edge.
    do_reset();
    send_byte(8'h90, a0);
    bus.valid_i = 1'b0;
    check("single_busy_up", 32'(busy_o), 32'd1);
    drain(fall);
    check("single_busy_fall", fall, a0 + 1 + FRAME);
    check("single_start_edge", (mon_start.size() > 0) ? mon_start[0] : 32'd0, a0 + 2);
    check("single_line_idle", 32'(txData_o), 32'd1);
    compare_frames("single");

    // Five bytes on consecutive cycles: FIFO fills, frames leave gapless.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(burst[i], acc[i]);
    bus.valid_i = 1'b0;
    check("burst_one_per_cycle", acc[4] - acc[0], 32'd4);
    check("burst_ready_full", 32'(bus.ready_o), 32'((5 - 1) < DEPTH));
    drain(fall);
    compare_frames("burst");
    if (mon_start.size() == 5) begin
      check("burst_first_start", mon_start[0], acc[0] + 2);
      check("burst_span", mon_start[4] + FRAME - mon_start[0], 32'(5 * FRAME));
    end else begin
      check("burst_frames_present", mon_start.size(), 32'd5);
    end

    // Reset 100 cycles into a frame with bytes still queued.
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), acc[i]);
    bus.valid_i = 1'b0;
    budget = 4 * FRAME;
    while (txData_o !== 1'b0 && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    check("abort_frame_started", 32'(txData_o), 32'd0);
    repeat (100) @(negedge clk_i);
    #1 nrst_i = 1'b0;
    #1;
    check("abort_tx_high", 32'(txData_o), 32'd1);
    check("abort_ready", 32'(bus.ready_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    model_reset();
    mon_clear();
    nrst_i = 1'b1;
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge clk_i);
      if (txData_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    check("abort_quiet_after", 32'(bad), 32'd0);
    check("abort_no_frames", mon_byte.size(), 32'd0);

    // Randomised streams with random gaps; running-status state carries across rounds.
    do_reset();
    for (int round = 0; round < 4; round++) begin
      int n;
      n = int'($urandom_range(3, 8));
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        case ($urandom_range(0, 3))
          0:       b = 8'h90 | 8'($urandom_range(0, 1));
          1:       b = 8'($urandom_range(0, 127));
          2:       b = 8'($urandom_range(8'hF0, 8'hFF));
          default: b = 8'($urandom);
        endcase
        send_byte(b, a0);
        if ($urandom_range(0, 2) == 0) begin
          bus.valid_i = 1'b0;
          repeat ($urandom_range(1, 2 * CPB)) @(negedge clk_i);
        end
      end
      bus.valid_i = 1'b0;
      drain(fall);
      compare_frames($sformatf("rand%0d", round));
      exp_q.delete();
      mon_clear();
    end

    // Running-status sequence (repeated 0x90 dropped only when the feature is built in).
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(rs_seq[i], a0);
    bus.valid_i = 1'b0;
    drain(fall);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    check("rs_expected_len", exp_q.size(), 32'd8);
`else
    check("rs_expected_len", exp_q.size(), 32'd10);
`endif
    compare_frames("rs");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
